program_out_capture: RTL

//  Receiving end of the CPU's program_out[15:0] result bus. Samples program_out every

---
 rtl/program_out_capture_pkg.sv | 13 +
 rtl/program_out_capture_if.sv | 28 ++
 rtl/program_out_capture_sync_fifo.sv | 72 +++++++
 rtl/program_out_capture.sv | 91 +++++++++
 4 files changed

// File: rtl/program_out_capture_pkg.sv
// Shared constants for the program_out capture path: CPU word width, queue sizing
// and the capture FSM encodings.
package program_out_capture_pkg;

  localparam int unsigned CPU_WORD_W = 16;
  localparam int unsigned PC_DEPTH   = 8;
  localparam int unsigned PC_ADDR_W  = 3;
  localparam int unsigned PC_DROP_W  = 8;

  localparam logic [0:0] PC_WAIT_FIRST = 1'b0;
  localparam logic [0:0] PC_RUN        = 1'b1;

endpackage

// File: rtl/program_out_capture_if.sv
// Observed CPU result bus plus the drain handshake and queue status of the capture block.
interface program_out_capture_if
  import program_out_capture_pkg::*;
#(
  parameter int unsigned DATA_W = CPU_WORD_W,
  parameter int unsigned ADDR_W = PC_ADDR_W,
  parameter int unsigned DROP_W = PC_DROP_W
);

  logic [DATA_W-1:0] program_out;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [ADDR_W:0]   fill_level;
  logic              overflow;
  logic [DROP_W-1:0] drop_count;

  modport slave (
    input  program_out, out_ready,
    output out_valid, out_data, fill_level, overflow, drop_count
  );

  modport master (
    output program_out, out_ready,
    input  out_valid, out_data, fill_level, overflow, drop_count
  );

endinterface

// File: rtl/program_out_capture_sync_fifo.sv
// First-word fall-through FIFO with wrap-bit pointers; head, valid, full and level
// are all registered from next-state values.
module program_out_capture_sync_fifo #(
  parameter  int unsigned DATA_W = 16,
  parameter  int unsigned DEPTH  = 8,
  localparam int unsigned ADDR_W = $clog2(DEPTH),
  localparam int unsigned PTR_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              valid,
  output logic              full,
  output logic [PTR_W-1:0]  level,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  level_q, level_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic              valid_q, valid_d;
  logic              full_q, full_d;
  logic              push_ok_c, pop_ok_c;

  // A pop on a full queue frees the slot the same edge, so the push still lands.
  always_comb begin
    pop_ok_c  = pop & valid_q;
    push_ok_c = push & (~full_q | pop_ok_c);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q + PTR_W'(push_ok_c);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop_ok_c);
    if (push_ok_c) begin
      mem_d[wr_ptr_q[ADDR_W-1:0]] = push_data;
    end
    level_d = wr_ptr_d - rd_ptr_d;
    valid_d = (wr_ptr_d != rd_ptr_d);
    full_d  = (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]) &&
              (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]);
    head_d  = mem_d[rd_ptr_d[ADDR_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
    end
  end

  assign valid = valid_q;
  assign full  = full_q;
  assign level = level_q;
  assign head  = head_q;

endmodule

// File: rtl/program_out_capture.sv
// Watches the CPU result bus, queues every new value, and counts changes lost to a
// full queue so a slow drain never silently loses a result.
module program_out_capture
  import program_out_capture_pkg::*;
#(
  parameter int unsigned DATA_W = CPU_WORD_W,
  parameter int unsigned DEPTH  = PC_DEPTH,
  parameter int unsigned ADDR_W = PC_ADDR_W,
  parameter int unsigned DROP_W = PC_DROP_W
) (
  input logic                  clock,
  input logic                  reset,
  program_out_capture_if.slave bus
);

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] last_seen_q, last_seen_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_count_q, drop_count_d;

  logic              capture_c, pop_c, drop_c;
  logic              fifo_valid, fifo_full;
  logic [ADDR_W:0]   fifo_level;
  logic [DATA_W-1:0] fifo_head;

  // The first post-reset sample is taken unconditionally; afterwards only changes.
  always_comb begin
    state_d      = state_q;
    last_seen_d  = last_seen_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    capture_c    = 1'b0;
    drop_c       = 1'b0;
    pop_c        = fifo_valid & bus.out_ready;

    if (state_q == PC_WAIT_FIRST) begin
      capture_c = 1'b1;
      state_d   = PC_RUN;
    end else begin
      capture_c = (bus.program_out != last_seen_q);
    end

    if (capture_c) begin
      last_seen_d = bus.program_out;
      drop_c      = fifo_full & ~pop_c;
    end

    if (drop_c) begin
      overflow_d = 1'b1;
      if (drop_count_q != '1) begin
        drop_count_d = drop_count_q + DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= PC_WAIT_FIRST;
      last_seen_q  <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      last_seen_q  <= last_seen_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  program_out_capture_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clock),
    .rst       (reset),
    .push      (capture_c),
    .push_data (bus.program_out),
    .pop       (pop_c),
    .valid     (fifo_valid),
    .full      (fifo_full),
    .level     (fifo_level),
    .head      (fifo_head)
  );

  assign bus.out_valid  = fifo_valid;
  assign bus.out_data   = fifo_head;
  assign bus.fill_level = fifo_level;
  assign bus.overflow   = overflow_q;
  assign bus.drop_count = drop_count_q;

endmodule
